dmem_bus_arbiter: RTL and testbench

- Shares the single-port data memory (dmem) and the seven-segment output register between two requesters: port 0 is the CPU data port, port 1 is the program/data loader (DMA-style, burst capable).
- Decodes byte addresses into the DMEM window and the SEG register, and arbitrates one access per cycle.
- Returns read data with fixed latency and flags out-of-window accesses.
- Replaces the purely combinational write/read select in the top level once the loader is added.

---
 rtl/dmem_bus_arbiter_if.sv | 33 +++
 rtl/dmem_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_arbiter_if.sv
// Requester and memory-side signals of the dmem/SEG bus arbiter.
// slave: the arbiter; master: the requesters plus the DMEM read port.
interface dmem_bus_arbiter_if #(
    parameter int AW = 11
);
    logic          req0, req1;
    logic          we0, we1;
    logic [31:0]   addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [31:0]   rdata;
    logic          err;
    logic [31:0]   err_addr;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          seg_we;
    logic [31:0]   seg_wdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err, err_addr,
               mem_addr, mem_we, mem_wdata, seg_we, seg_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err, err_addr,
               mem_addr, mem_we, mem_wdata, seg_we, seg_wdata
    );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Two-port arbiter for the single-port DMEM and the SEG register.
// Port 0 = CPU, port 1 = loader. One access per cycle, combinational grant,
// registered read data one cycle later, out-of-window accesses flagged.
module dmem_bus_arbiter #(
    parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
    parameter int          DMEM_WORDS = 2048,
    parameter logic [31:0] SEG_ADDR   = 32'h1002_0000,
    parameter int          STARVE_MAX = 4,
    parameter int          BURST_MAX  = 8
) (
    input logic               clk,
    input logic               reset,
    dmem_bus_arbiter_if.slave bus
);
    localparam int          AW         = $clog2(DMEM_WORDS);
    localparam int          SW         = $clog2(STARVE_MAX + 1);
    localparam int          BW         = $clog2(BURST_MAX + 1);
    localparam logic [31:0] DMEM_END   = DMEM_BASE + 32'(4 * DMEM_WORDS);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

    typedef enum logic {OWN_CPU, OWN_LDR} owner_t;

    owner_t        owner_last;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt;
    logic [31:0]   seg_shadow;
    logic          rvalid0_q, rvalid1_q, err_q;
    logic [31:0]   rdata_q, err_addr_q;

    logic        pick_ldr, gnt0, gnt1, any_gnt;
    logic        sel_we, hit_dmem, hit_seg, miss, mem_we, seg_we;
    logic [31:0] sel_addr, sel_wdata;

    // Winner selection: burst continuation, then burst cap, then starvation relief, else CPU.
    always_comb begin
        pick_ldr = 1'b0;
        if (bus.req1 && !bus.req0) begin
            pick_ldr = 1'b1;
        end else if (bus.req1 && bus.req0) begin
            if (owner_last == OWN_LDR && burst_cnt < BURST_TOP)
                pick_ldr = 1'b1;
            else if (burst_cnt == BURST_TOP)
                pick_ldr = 1'b0;
            else
                pick_ldr = (starve_cnt == STARVE_TOP);
        end
    end

    // Grants are held off for the whole time reset is asserted.
    assign gnt1    = reset && pick_ldr;
    assign gnt0    = reset && bus.req0 && !pick_ldr;
    assign any_gnt = gnt0 || gnt1;

    // With no grant the mux rests on port 0, so the memory address follows the CPU.
    assign sel_addr  = pick_ldr ? bus.addr1  : bus.addr0;
    assign sel_wdata = pick_ldr ? bus.wdata1 : bus.wdata0;
    assign sel_we    = pick_ldr ? bus.we1    : bus.we0;

    // DMEM takes precedence should the SEG address ever be placed inside the window.
    assign hit_dmem = (sel_addr >= DMEM_BASE) && (sel_addr < DMEM_END);
    assign hit_seg  = (sel_addr[31:2] == SEG_ADDR[31:2]) && !hit_dmem;
    assign miss     = !hit_dmem && !hit_seg;
    assign mem_we   = any_gnt && sel_we && hit_dmem;
    assign seg_we   = any_gnt && sel_we && hit_seg;

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.mem_addr  = AW'((sel_addr - DMEM_BASE) >> 2);
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_we    = mem_we;
    assign bus.seg_we    = seg_we;
    assign bus.seg_wdata = sel_wdata;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.err_addr  = err_addr_q;

    // Fairness history: who won last cycle and how long each side has been kept waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_last <= OWN_CPU;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            owner_last <= gnt1 ? OWN_LDR : OWN_CPU;
            if (gnt1 || !bus.req1)
                starve_cnt <= '0;
            else if (gnt0 && starve_cnt != STARVE_TOP)
                starve_cnt <= starve_cnt + 1'b1;
            if (gnt0 || !bus.req0)
                burst_cnt <= '0;
            else if (gnt1 && burst_cnt != BURST_TOP)
                burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Read return, error report and SEG shadow update, all one cycle behind the grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            seg_shadow <= '0;
        end else begin
            rvalid0_q <= gnt0 && !bus.we0;
            rvalid1_q <= gnt1 && !bus.we1;
            err_q     <= any_gnt && miss;
            if (any_gnt && miss)
                err_addr_q <= sel_addr;
            if (any_gnt && !sel_we)
                rdata_q <= hit_dmem ? bus.mem_rdata :
                           hit_seg  ? seg_shadow    : 32'hDEAD_BEEF;
            if (seg_we)
                seg_shadow <= sel_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the arbitration rules.
module tb_dmem_bus_arbiter;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          WORDS = 2048;
    localparam logic [31:0] SEG   = 32'h1002_0000;
    localparam int          SMAX  = 4;
    localparam int          BMAX  = 8;
    localparam logic [31:0] B0 = 32'hA000_0001, B1 = 32'hB000_0002, B2 = 32'hC000_0003;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_bus_arbiter_if #(.AW(11)) bus();

    dmem_bus_arbiter #(
        .DMEM_BASE(BASE), .DMEM_WORDS(WORDS), .SEG_ADDR(SEG),
        .STARVE_MAX(SMAX), .BURST_MAX(BMAX)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory the arbiter drives: combinational read, write on the clock edge.
    logic [31:0] dmem [WORDS];
    always @(posedge clk) if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = dmem[bus.mem_addr];

    // Reference-model state for the randomized run.
    logic [31:0] ref_mem [int];
    logic [31:0] m_seg;
    bit          m_prev_ldr;
    int          m_starve, m_burst;
    bit          pv [2];
    bit          pwe [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];

    task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clk);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, BASE, 0, 0, 0, BASE, 0);
        tick();
    endtask

    function automatic int cls_of(input logic [31:0] a);
        if (a >= BASE && a < BASE + 32'(WORDS * 4)) return 0;
        if ((a >> 2) == (SEG >> 2)) return 1;
        return 2;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = BASE; bus.wdata0 = 32'h5A5A;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = SEG;  bus.wdata1 = 32'h77;
        tick();
        n_tests++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b%b want=00", bus.gnt0, bus.gnt1); end
        n_tests++; if (bus.mem_we !== 1'b0 || bus.seg_we !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got=%b%b want=00", bus.mem_we, bus.seg_we); end
        n_tests++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b%b want=000", bus.rvalid0, bus.rvalid1, bus.err); end
        n_tests++; if (bus.rdata !== 32'h0 || bus.err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h/%h want=0/0", bus.rdata, bus.err_addr); end
        drive(0, 0, BASE, 0, 0, 0, BASE, 0);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_dmem_rw();
        drive(1, 1, 32'h1001_0004, 32'h1234_5678, 0, 0, BASE, 0);
        n_tests++; if (bus.gnt0 !== 1'b1 || bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rw_write_strobe got=%b%b want=11", bus.gnt0, bus.mem_we); end
        n_tests++; if (bus.mem_addr !== 11'd1 || bus.mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_write_bus got=%0d/%h want=1/12345678", bus.mem_addr, bus.mem_wdata); end
        tick();
        drive(1, 0, 32'h1001_0004, 0, 0, 0, BASE, 0);
        n_tests++; if (bus.gnt0 !== 1'b1 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rw_read_gnt got=%b%b want=10", bus.gnt0, bus.mem_we); end
        tick();
        n_tests++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_readback got=%b/%h want=1/12345678", bus.rvalid0, bus.rdata); end
        idle();
        n_tests++; if (bus.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rw_rvalid_drop got=%b want=0", bus.rvalid0); end
    endtask

    task automatic test_seg();
        drive(0, 0, BASE, 0, 1, 1, SEG, 32'hFF);
        n_tests++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL seg_gnt got=%b%b want=01", bus.gnt0, bus.gnt1); end
        n_tests++; if (bus.seg_we !== 1'b1 || bus.seg_wdata !== 32'hFF || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL seg_write got=%b/%h/%b want=1/ff/0", bus.seg_we, bus.seg_wdata, bus.mem_we); end
        tick();
        drive(1, 0, SEG, 0, 0, 0, BASE, 0);
        tick();
        n_tests++; if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.rdata !== 32'hFF) begin n_fail++; $display("FAIL seg_read got=%b%b/%h want=10/ff", bus.rvalid0, bus.rvalid1, bus.rdata); end
        idle();
    endtask

    task automatic test_miss();
        drive(1, 0, 32'h1001_2000, 0, 0, 0, BASE, 0);
        n_tests++; if (bus.gnt0 !== 1'b1 || bus.mem_we !== 1'b0 || bus.seg_we !== 1'b0) begin n_fail++; $display("FAIL miss_grant got=%b%b%b want=100", bus.gnt0, bus.mem_we, bus.seg_we); end
        tick();
        n_tests++; if (bus.err !== 1'b1 || bus.err_addr !== 32'h1001_2000) begin n_fail++; $display("FAIL miss_err got=%b/%h want=1/10012000", bus.err, bus.err_addr); end
        n_tests++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL miss_rdata got=%b/%h want=1/deadbeef", bus.rvalid0, bus.rdata); end
        idle();
        n_tests++; if (bus.err !== 1'b0 || bus.err_addr !== 32'h1001_2000) begin n_fail++; $display("FAIL miss_pulse got=%b/%h want=0/10012000", bus.err, bus.err_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = B0; vals[1] = B1; vals[2] = B2;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, BASE + 32'(4 * i), vals[i], 0, 0, BASE, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, BASE + 32'(4 * i), 0, 0, 0, BASE, 0);
            tick();
            n_tests++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== vals[i]) begin n_fail++; $display("FAIL b2b_read%0d got=%b/%h want=1/%h", i, bus.rvalid0, bus.rdata, vals[i]); end
        end
        idle();
        n_tests++; if (bus.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%b want=0", bus.rvalid0); end
    endtask

    // Both ports saturating the bus: 4 CPU grants, then an 8-grant loader burst, repeating.
    task automatic test_fairness();
        bit exp_cpu;
        for (int i = 0; i < 26; i++) begin
            drive(1, 0, BASE, 0, 1, 0, BASE + 4, 0);
            exp_cpu = (i % 12) < 4;
            n_tests++; if (bus.gnt0 !== exp_cpu || bus.gnt1 !== !exp_cpu) begin n_fail++; $display("FAIL fair_cycle%0d got=%b%b want=%b%b", i, bus.gnt0, bus.gnt1, exp_cpu, !exp_cpu); end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        int g, k, w, c;
        logic [31:0] a, e_rdata, e_err_addr;
        bit e_rv0, e_rv1, e_err, e_mw, e_sw;
        drive(0, 0, BASE, 0, 1, 1, SEG, 32'h0);
        tick();
        idle();
        m_seg = 0; m_prev_ldr = 0; m_starve = 0; m_burst = 0;
        pv[0] = 0; pv[1] = 0; pa[0] = BASE; pa[1] = BASE; pd[0] = 0; pd[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 99) < 60) begin
                    k = int'($urandom_range(0, 9));
                    pwe[p] = 1'($urandom_range(0, 1));
                    pd[p] = $urandom;
                    if (k < 6) begin
                        w = 16 + 8 * p + int'($urandom_range(0, 7));
                        if (p == 0 && k == 5) w = WORDS - 1;
                        pa[p] = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
                        if (!pwe[p] && !ref_mem.exists(w)) pwe[p] = 1;
                    end else if (k < 8) pa[p] = SEG + 32'($urandom_range(0, 3));
                    else if (k == 8) pa[p] = ($urandom_range(0, 1) != 0) ? BASE + 32'(WORDS * 4) : BASE - 4;
                    else pa[p] = $urandom | 32'h8000_0000;
                    pv[p] = 1;
                end
            end
            if (pv[0] && pv[1]) begin
                if (m_prev_ldr && m_burst < BMAX) g = 1;
                else if (m_burst >= BMAX) g = 0;
                else if (m_starve >= SMAX) g = 1;
                else g = 0;
            end else g = pv[1] ? 1 : (pv[0] ? 0 : -1);
            drive(pv[0], pwe[0], pa[0], pd[0], pv[1], pwe[1], pa[1], pd[1]);
            n_tests++; if (bus.gnt0 !== (g == 0) || bus.gnt1 !== (g == 1)) begin n_fail++; $display("FAIL rnd_gnt c%0d got=%b%b want=%b%b", cyc, bus.gnt0, bus.gnt1, g == 0, g == 1); end
            a = (g >= 0) ? pa[g] : pa[0];
            c = cls_of(a);
            e_mw = (g >= 0) && pwe[g] && c == 0;
            e_sw = (g >= 0) && pwe[g] && c == 1;
            n_tests++; if (bus.mem_we !== e_mw || bus.seg_we !== e_sw) begin n_fail++; $display("FAIL rnd_strobe c%0d got=%b%b want=%b%b", cyc, bus.mem_we, bus.seg_we, e_mw, e_sw); end
            if (e_mw || g < 0) begin
                n_tests++; if (bus.mem_addr !== 11'((a - BASE) >> 2)) begin n_fail++; $display("FAIL rnd_mem_addr c%0d got=%0d want=%0d", cyc, bus.mem_addr, 11'((a - BASE) >> 2)); end
            end
            if (e_mw) begin
                n_tests++; if (bus.mem_wdata !== pd[g]) begin n_fail++; $display("FAIL rnd_mem_wdata c%0d got=%h want=%h", cyc, bus.mem_wdata, pd[g]); end
            end
            if (e_sw) begin
                n_tests++; if (bus.seg_wdata !== pd[g]) begin n_fail++; $display("FAIL rnd_seg_wdata c%0d got=%h want=%h", cyc, bus.seg_wdata, pd[g]); end
            end
            e_rv0 = (g == 0) && !pwe[0];
            e_rv1 = (g == 1) && !pwe[1];
            e_err = (g >= 0) && c == 2;
            e_err_addr = a;
            e_rdata = 32'hDEAD_BEEF;
            if (g >= 0 && !pwe[g]) begin
                if (c == 0) e_rdata = ref_mem[int'((a - BASE) >> 2)];
                else if (c == 1) e_rdata = m_seg;
            end
            if (e_mw) ref_mem[int'((a - BASE) >> 2)] = pd[g];
            if (e_sw) m_seg = pd[g];
            if (g == 1 || !pv[1]) m_starve = 0; else if (g == 0 && m_starve < SMAX) m_starve++;
            if (g == 0 || !pv[0]) m_burst = 0;  else if (g == 1 && m_burst < BMAX) m_burst++;
            m_prev_ldr = (g == 1);
            if (g >= 0) pv[g] = 0;
            tick();
            n_tests++; if (bus.rvalid0 !== e_rv0 || bus.rvalid1 !== e_rv1 || bus.err !== e_err) begin n_fail++; $display("FAIL rnd_flags c%0d got=%b%b%b want=%b%b%b", cyc, bus.rvalid0, bus.rvalid1, bus.err, e_rv0, e_rv1, e_err); end
            if (e_rv0 || e_rv1) begin
                n_tests++; if (bus.rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d got=%h want=%h", cyc, bus.rdata, e_rdata); end
            end
            if (e_err) begin
                n_tests++; if (bus.err_addr !== e_err_addr) begin n_fail++; $display("FAIL rnd_err_addr c%0d got=%h want=%h", cyc, bus.err_addr, e_err_addr); end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        // Read granted, reset lands before the capturing edge: the read never returns.
        drive(1, 0, BASE + 8, 0, 0, 0, BASE, 0);
        n_tests++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_gnt got=%b want=1", bus.gnt0); end
        #1 reset = 1'b0;
        #1;
        n_tests++; if (bus.gnt0 !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_force got=%b%b want=00", bus.gnt0, bus.mem_we); end
        tick();
        n_tests++; if (bus.rvalid0 !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rvalid got=%b%b want=00", bus.rvalid0, bus.err); end
        drive(0, 0, BASE, 0, 0, 0, BASE, 0);
        reset = 1'b1;
        // Completed read, then reset mid-cycle: outputs clear without waiting for an edge.
        drive(1, 0, BASE + 8, 0, 0, 0, BASE, 0);
        tick();
        n_tests++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== B2) begin n_fail++; $display("FAIL rst_pre_read got=%b/%h want=1/%h", bus.rvalid0, bus.rdata, B2); end
        #1 reset = 1'b0;
        #1;
        n_tests++; if (bus.rvalid0 !== 1'b0 || bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_async got=%b/%h want=0/0", bus.rvalid0, bus.rdata); end
        drive(0, 0, BASE, 0, 0, 0, BASE, 0);
        reset = 1'b1;
        // SEG shadow was cleared by the reset.
        drive(1, 0, SEG, 0, 0, 0, BASE, 0);
        tick();
        n_tests++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_seg_clear got=%b/%h want=1/0", bus.rvalid0, bus.rdata); end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = BASE; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = BASE; bus.wdata1 = 0;
        test_reset();
        test_dmem_rw();
        test_seg();
        test_miss();
        test_back_to_back();
        test_fairness();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
